// File: rtl/wavefront_issue_scheduler.sv
// wavefront_issue_scheduler
//  Buffers one fetched instruction per wavefront and issues one eligible
//  wavefront per cycle, round-robin, to the SIMD32 decoder. Issue is gated by
//  decoder backpressure, a per-wavefront halt mask and per-wavefront credits
//  that are consumed on issue and returned on retire.
// Ports:
//  clk, reset                     clock, synchronous active-high reset
//  fetch_valid/fetch_wf/fetch_inst fetch request into slot[fetch_wf]
//  fetch_ready                    slot[fetch_wf] is empty (combinational)
//  wf_halt                        per-wavefront issue mask (1 = not eligible)
//  retire_valid/retire_wf         returns one credit to retire_wf
//  decoder_stall                  decoder backpressure; outputs hold
//  inst/wavefront_num/issue_valid registered issue outputs to decoder
//  slot_occupied                  per-wavefront buffer status
//  credit_err                     sticky retire-without-outstanding error
module wavefront_issue_scheduler #(
    parameter int                 NUM_WF          = 8,
    parameter int                 WF_W            = $clog2(NUM_WF),
    parameter int                 INST_W          = 32,
    parameter int                 MAX_OUTSTANDING = 2,
    parameter logic [INST_W-1:0]  IDLE_INST       = 32'hBF800000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic [WF_W-1:0]   fetch_wf,
    input  logic [INST_W-1:0] fetch_inst,
    output logic              fetch_ready,
    input  logic [NUM_WF-1:0] wf_halt,
    input  logic              retire_valid,
    input  logic [WF_W-1:0]   retire_wf,
    input  logic              decoder_stall,
    output logic [INST_W-1:0] inst,
    output logic [WF_W-1:0]   wavefront_num,
    output logic              issue_valid,
    output logic [NUM_WF-1:0] slot_occupied,
    output logic              credit_err
);

    // Credits range 0..7, so three bits cover every legal MAX_OUTSTANDING.
    localparam int               CRED_W   = 3;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);
    localparam logic [CRED_W-1:0] CRED_ONE = 3'd1;
    localparam logic [CRED_W-1:0] CRED_ZERO = 3'd0;

    logic [NUM_WF-1:0] slot_occupied_r;
    logic [INST_W-1:0] slot_inst_r [NUM_WF];
    logic [CRED_W-1:0] credit_r [NUM_WF];
    logic [WF_W-1:0]   last_grant_r;
    logic [INST_W-1:0] inst_r;
    logic [WF_W-1:0]   wavefront_num_r;
    logic              issue_valid_r;
    logic              credit_err_r;

    logic [NUM_WF-1:0] elig_s;
    logic              grant_valid_s;
    logic [WF_W-1:0]   grant_s;
    logic              issue_fire_s;
    logic [NUM_WF-1:0] issue_oh_s;
    logic [NUM_WF-1:0] retire_oh_s;
    logic [NUM_WF-1:0] fetch_oh_s;
    logic              credit_err_set_s;

    assign fetch_ready   = ~slot_occupied_r[fetch_wf];
    assign slot_occupied = slot_occupied_r;
    assign inst          = inst_r;
    assign wavefront_num = wavefront_num_r;
    assign issue_valid   = issue_valid_r;
    assign credit_err    = credit_err_r;

    // Eligibility: occupied, not halted, at least one credit left.
    always_comb begin
        elig_s = {NUM_WF{1'b0}};
        for (int w = 0; w < NUM_WF; w++) begin
            elig_s[w] = slot_occupied_r[w] & ~wf_halt[w] & (credit_r[w] != CRED_ZERO);
        end
    end

    // Round-robin search starting just after the last grant; first hit wins.
    always_comb begin
        logic [WF_W-1:0] idx_v;
        logic            take_v;
        grant_valid_s = 1'b0;
        grant_s       = {WF_W{1'b0}};
        idx_v         = {WF_W{1'b0}};
        take_v        = 1'b0;
        for (int i = 1; i <= NUM_WF; i++) begin
            idx_v         = WF_W'((int'(last_grant_r) + i) % NUM_WF);
            take_v        = ~grant_valid_s & elig_s[idx_v];
            grant_s       = take_v ? idx_v : grant_s;
            grant_valid_s = grant_valid_s | take_v;
        end
    end

    // Per-wavefront event decode for issue, retire and accepted fetch.
    always_comb begin
        issue_fire_s = ~decoder_stall & grant_valid_s;
        for (int w = 0; w < NUM_WF; w++) begin
            issue_oh_s[w]  = issue_fire_s & (grant_s == WF_W'(w));
            retire_oh_s[w] = retire_valid & (retire_wf == WF_W'(w));
            fetch_oh_s[w]  = fetch_valid & fetch_ready & (fetch_wf == WF_W'(w));
        end
        // A retire that coincides with an issue of the same wavefront is a
        // net-zero credit change, so it can never overflow the counter.
        credit_err_set_s = retire_valid & ~issue_oh_s[retire_wf]
                         & (credit_r[retire_wf] == CRED_MAX);
    end

    // Slot, credit, arbitration and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WF; w++) begin
                slot_occupied_r[w] <= 1'b0;
                slot_inst_r[w]     <= {INST_W{1'b0}};
                credit_r[w]        <= CRED_MAX;
            end
            last_grant_r    <= WF_W'(NUM_WF - 1);
            inst_r          <= IDLE_INST;
            wavefront_num_r <= {WF_W{1'b0}};
            issue_valid_r   <= 1'b0;
            credit_err_r    <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WF; w++) begin
                // Issue needs an occupied slot and fetch needs an empty one,
                // so the two never target the same slot in one cycle.
                if (issue_oh_s[w]) begin
                    slot_occupied_r[w] <= 1'b0;
                end else if (fetch_oh_s[w]) begin
                    slot_occupied_r[w] <= 1'b1;
                    slot_inst_r[w]     <= fetch_inst;
                end
                case ({issue_oh_s[w], retire_oh_s[w]})
                    2'b10: credit_r[w] <= credit_r[w] - CRED_ONE;
                    2'b01: begin
                        if (credit_r[w] != CRED_MAX) begin
                            credit_r[w] <= credit_r[w] + CRED_ONE;
                        end
                    end
                    default: credit_r[w] <= credit_r[w];
                endcase
            end
            if (credit_err_set_s) begin
                credit_err_r <= 1'b1;
            end
            if (!decoder_stall) begin
                if (grant_valid_s) begin
                    inst_r          <= slot_inst_r[grant_s];
                    wavefront_num_r <= grant_s;
                    issue_valid_r   <= 1'b1;
                    last_grant_r    <= grant_s;
                end else begin
                    inst_r        <= IDLE_INST;
                    issue_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wavefront_issue_scheduler.sv
module tb_wavefront_issue_scheduler;

    localparam int          NWF  = 8;
    localparam int          MAXO = 2;
    localparam logic [31:0] IDLE = 32'hBF800000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [2:0]  fetch_wf = 3'd0;
    logic [31:0] fetch_inst = 32'd0;
    logic        fetch_ready;
    logic [7:0]  wf_halt = 8'd0;
    logic        retire_valid = 1'b0;
    logic [2:0]  retire_wf = 3'd0;
    logic        decoder_stall = 1'b0;
    logic [31:0] inst;
    logic [2:0]  wavefront_num;
    logic        issue_valid;
    logic [7:0]  slot_occupied;
    logic        credit_err;

    wavefront_issue_scheduler dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_wf(fetch_wf), .fetch_inst(fetch_inst),
        .fetch_ready(fetch_ready), .wf_halt(wf_halt),
        .retire_valid(retire_valid), .retire_wf(retire_wf),
        .decoder_stall(decoder_stall), .inst(inst), .wavefront_num(wavefront_num),
        .issue_valid(issue_valid), .slot_occupied(slot_occupied), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at_edge;
        logic [2:0]  wf;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          edge_n = 0;

    // Reference model: what the scheduler should hold, in plain terms.
    logic [7:0]  m_occ = 8'd0;
    logic [31:0] m_inst [NWF];
    int          m_cred [NWF];
    int          m_last = NWF - 1;
    logic        m_err = 1'b0;
    bit          m_known = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, req, edge_n);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check observable
    // state against the model, then advance the model across the next edge.
    task automatic cyc(input bit rst, input bit fv, input int fw, input logic [31:0] fi,
                       input logic [7:0] halt, input bit rv, input int rw, input bit st);
        bit found;
        bit iss;
        int g;
        int w;
        bit facc;
        @(negedge clk);
        reset = rst; fetch_valid = fv; fetch_wf = 3'(fw); fetch_inst = fi;
        wf_halt = halt; retire_valid = rv; retire_wf = 3'(rw); decoder_stall = st;
        #1;
        if (m_known) begin
            chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, ~m_occ[fw]});
            chk("slot_occupied", {24'd0, slot_occupied}, {24'd0, m_occ});
            chk("credit_err", {31'd0, credit_err}, {31'd0, m_err});
        end
        if (rst) begin
            m_occ = 8'd0; m_last = NWF - 1; m_err = 1'b0; m_known = 1'b1;
            for (int k = 0; k < NWF; k++) m_cred[k] = MAXO;
            exp_q.delete();
        end else begin
            found = 1'b0; g = 0;
            for (int k = 1; k <= NWF; k++) begin
                w = (m_last + k) % NWF;
                if (!found && m_occ[w] && !halt[w] && m_cred[w] > 0) begin
                    found = 1'b1; g = w;
                end
            end
            facc = fv && !m_occ[fw];
            iss  = !st && found;
            if (iss) begin
                exp_q.push_back('{edge_n + 1, 3'(g), m_inst[g]});
                m_occ[g] = 1'b0; m_cred[g] = m_cred[g] - 1; m_last = g;
            end
            if (rv) begin
                if (iss && g == rw) m_cred[rw] = m_cred[rw] + 1;
                else if (m_cred[rw] == MAXO) m_err = 1'b1;
                else m_cred[rw] = m_cred[rw] + 1;
            end
            if (facc) begin
                m_occ[fw] = 1'b1; m_inst[fw] = fi;
            end
        end
    endtask

    task automatic idle(input int n, input logic [7:0] halt, input bit st);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, halt, 0, 0, st);
    endtask

    task automatic fetch(input int fw, input logic [7:0] halt, input bit st);
        cyc(0, 1, fw, $urandom, halt, 0, 0, st);
    endtask

    // Monitor: at every edge decide what the decoder should see and compare.
    initial begin
        bit          r_at;
        bit          s_at;
        exp_t        e;
        logic        last_iv;
        logic [31:0] last_word;
        logic [2:0]  last_wf;
        last_iv = 1'b0; last_word = IDLE; last_wf = 3'd0;
        forever begin
            @(posedge clk);
            edge_n++;
            r_at = reset; s_at = decoder_stall;
            #1;
            if (r_at) begin
                chk("reset issue_valid", {31'd0, issue_valid}, 32'd0);
                chk("reset inst", inst, IDLE);
                chk("reset wavefront_num", {29'd0, wavefront_num}, 32'd0);
                last_iv = 1'b0; last_word = IDLE; last_wf = 3'd0;
            end else if (s_at) begin
                chk("stall hold issue_valid", {31'd0, issue_valid}, {31'd0, last_iv});
                chk("stall hold inst", inst, last_word);
                chk("stall hold wavefront_num", {29'd0, wavefront_num}, {29'd0, last_wf});
            end else if (exp_q.size() > 0 && exp_q[0].at_edge == edge_n) begin
                e = exp_q.pop_front();
                chk("issue_valid", {31'd0, issue_valid}, 32'd1);
                chk("issue wavefront_num", {29'd0, wavefront_num}, {29'd0, e.wf});
                chk("issue inst", inst, e.word);
                last_iv = 1'b1; last_word = e.word; last_wf = e.wf;
            end else begin
                chk("idle issue_valid", {31'd0, issue_valid}, 32'd0);
                chk("idle inst", inst, IDLE);
                chk("idle wavefront_num", {29'd0, wavefront_num}, {29'd0, last_wf});
                last_iv = 1'b0; last_word = IDLE;
            end
        end
    end

    initial begin
        int fw;
        int rw;
        bit rv;
        int st_pct;
        // 1: in-order issue after reset, then idle.
        cyc(1, 0, 0, 32'd0, 8'h00, 0, 0, 0);
        cyc(1, 0, 0, 32'd0, 8'h00, 0, 0, 0);
        for (int w = 0; w < 4; w++) fetch(w, 8'h00, 0);
        idle(4, 8'h00, 0);
        for (int w = 0; w < 4; w++) cyc(0, 0, 0, 32'd0, 8'h00, 1, w, 0);
        // 2: slots 1,5,7 with last_grant=5 -> 7,1,5, then refill and wrap.
        cyc(1, 0, 0, 32'd0, 8'h00, 0, 0, 0);
        fetch(5, 8'h00, 0);
        idle(1, 8'h00, 0);
        cyc(0, 0, 0, 32'd0, 8'hFF, 1, 5, 0);
        fetch(1, 8'hFF, 0); fetch(5, 8'hFF, 0); fetch(7, 8'hFF, 0);
        idle(1, 8'h00, 0);
        fetch(1, 8'h00, 0);
        fetch(7, 8'h00, 0);
        idle(4, 8'h00, 0);
        // 3: wf2 issued, then held under a 3-cycle stall while wf3 waits.
        cyc(1, 0, 0, 32'd0, 8'h00, 0, 0, 0);
        fetch(2, 8'h00, 0);
        fetch(3, 8'h00, 0);
        idle(3, 8'h00, 1);
        idle(2, 8'h00, 0);
        // 4: credit exhaustion, retire release, issue+retire same cycle.
        cyc(1, 0, 0, 32'd0, 8'h00, 0, 0, 0);
        fetch(0, 8'h00, 0); idle(1, 8'h00, 0);
        fetch(0, 8'h00, 0); idle(1, 8'h00, 0);
        fetch(0, 8'h00, 0); idle(3, 8'h00, 0);
        cyc(0, 0, 0, 32'd0, 8'h00, 1, 0, 0);
        idle(1, 8'h00, 0);
        fetch(0, 8'h00, 0);
        cyc(0, 0, 0, 32'd0, 8'h00, 1, 0, 0);
        cyc(0, 0, 0, 32'd0, 8'h00, 1, 0, 0);
        idle(2, 8'h00, 0);
        // 5: over-retire sets sticky credit_err; halted slot waits for unhalt.
        cyc(0, 0, 0, 32'd0, 8'h00, 1, 4, 0);
        fetch(6, 8'h40, 0);
        idle(5, 8'h40, 0);
        idle(NWF, 8'h00, 0);
        // 6: reset while stalled with four occupied slots.
        for (int w = 0; w < 4; w++) fetch(w, 8'hFF, 1);
        cyc(1, 0, 0, 32'd0, 8'hFF, 0, 0, 1);
        for (int w = 0; w < NWF; w++) cyc(0, 0, w, 32'd0, 8'h00, 0, 0, 0);
        // Randomized traffic with varying stall pressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            st_pct = ((i / 500) % 3 == 0) ? 10 : (((i / 500) % 3 == 1) ? 50 : 0);
            fw = $urandom_range(0, NWF - 1);
            rw = $urandom_range(0, NWF - 1);
            if (m_cred[rw] < MAXO) rv = ($urandom_range(0, 1) == 1);
            else rv = ($urandom_range(0, 19) == 0);
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), fw, $urandom,
                ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00, rv, rw,
                ($urandom_range(0, 99) < st_pct));
        end
        idle(NWF + 4, 8'h00, 0);
        chk("expected issues left undelivered", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
